// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and default geometry.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/serial_digit_adder_if.sv
// Request/result bundle of the digit-serial adder; master issues additions, slave computes them.
interface serial_digit_adder_if
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cy_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cy_out;
  logic             ovf;

  modport master (
    output start, a, b, cy_in,
    input  ready, done, sum, cy_out, ovf
  );

  modport slave (
    input  start, a, b, cy_in,
    output ready, done, sum, cy_out, ovf
  );

endinterface

// File: rtl/serial_digit_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells; also exposes
// the carry into its MSB so the caller can derive two's-complement overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT - 1];

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: adds WIDTH-bit operands DIGIT bits per cycle, LSB digit first,
// reporting the sum, unsigned carry and signed overflow with a one-cycle done pulse.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input logic               clk,
  input logic               rst,
  serial_digit_adder_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state;
  logic [CNT_W-1:0] k;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cy_q;
  logic             ovf_q;
  logic             ready_q;
  logic             done_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;

  assign a_dig = a_q[int'(k) * DIGIT +: DIGIT];
  assign b_dig = b_q[int'(k) * DIGIT +: DIGIT];

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (a_dig),
    .b     (b_dig),
    .cin   (carry_q),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // Operand registers hold data only and are left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
      k       <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cy_in;
            k       <= '0;
            ready_q <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          sum_q[int'(k) * DIGIT +: DIGIT] <= d_sum;
          carry_q                         <= d_cout;
          if (k == LAST) begin
            cy_q   <= d_cout;
            ovf_q  <= d_cmsb ^ d_cout;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.sum    = sum_q;
  assign bus.cy_out = cy_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: doc/serial_digit_adder.md
SERIAL_DIGIT_ADDER -- requirements
Module: serial_digit_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT, and DIGIT SHALL be at least 1.
REQ-003 SHALL have one clock, clk, an input of width 1; all state updates on its rising edge.
REQ-004 SHALL have rst, an input of width 1; reset is synchronous and active-high.
REQ-005 SHALL have start, an input of width 1: request an addition, sampled only when ready=1.
REQ-006 SHALL have a, an input of width WIDTH: operand A, captured on the accepted start.
REQ-007 SHALL have b, an input of width WIDTH: operand B, captured on the accepted start.
REQ-008 SHALL have cy_in, an input of width 1: carry-in, captured on the accepted start.
REQ-009 SHALL have ready, an output of width 1: block idle and able to accept start.
REQ-010 SHALL have done, an output of width 1: single-cycle pulse marking that sum/cy_out/ovf are valid.
REQ-011 SHALL have sum, an output of width WIDTH: the result, equal to a+b+cy_in mod 2^WIDTH.
REQ-012 SHALL have cy_out, an output of width 1: unsigned carry out of the MSB.
REQ-013 SHALL have ovf, an output of width 1: two's-complement overflow, equal to the carry into the MSB XOR cy_out.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; N = WIDTH/DIGIT.
REQ-015 In IDLE: ready=1; start=1 SHALL latch a, b and cy_in into operand registers, clear the digit counter, load the carry register with cy_in, and move to BUSY.
REQ-016 In BUSY: each cycle SHALL add digit k (bits k*DIGIT+DIGIT-1..k*DIGIT, LSB digit first) of A and B plus the carry register, write the DIGIT-bit result into sum digit k, update the carry register, and increment k.
REQ-017 At the last digit (k=N-1), BUSY SHALL capture the carry into the MSB for ovf and transition to DONE.
REQ-018 In DONE: done=1 for exactly one cycle, ready=0; the FSM SHALL return to IDLE on the next edge.
REQ-019 Latency: with start accepted at edge t, done SHALL be high in the cycle following edge t+N; with N=1 (DIGIT=WIDTH), done SHALL be high in the cycle after edge t+1.
REQ-020 sum, cy_out and ovf SHALL be stable from the done cycle until the next accepted start, and SHALL not be updated in BUSY until that digit is computed.
REQ-021 start while in BUSY or DONE SHALL be ignored, with no queueing.
REQ-022 Input changes on a/b/cy_in after acceptance SHALL not affect the result.
REQ-023 The digit counter SHALL be $clog2(N) bits, minimum 1, and SHALL not wrap beyond N-1.

Reset
REQ-024 rst=1 SHALL force IDLE, ready=1, done=0, sum=0, cy_out=0, ovf=0, counter=0, carry register=0, with priority over start.
REQ-025 rst asserted mid-BUSY SHALL abort the operation; no done SHALL be produced for it.

Structure
REQ-026 FSM state encodings and the default WIDTH/DIGIT constants SHALL live in the shared adder package/include.
REQ-027 Per-cycle digit addition SHALL be a combinational sub-module digit_adder (DIGIT-bit a, b, cin -> sum, cout, c_msb) built from full-adder cells.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-028 The bench SHALL apply a=0xFFFF, b=0x0001, cy_in=0 -> sum=0x0000, cy_out=1, ovf=0, with done exactly 5 cycles after the start edge.
REQ-029 The bench SHALL apply a=0x7FFF, b=0x0001, cy_in=0 -> sum=0x8000, cy_out=0, ovf=1.
REQ-030 The bench SHALL apply a=0x1234, b=0x4321, cy_in=1 -> sum=0x5556, cy_out=0, ovf=0; it SHALL then apply start held high through BUSY with new operands -> second start ignored, result unchanged, one done pulse.
REQ-031 The bench SHALL assert rst at the third BUSY cycle -> all outputs 0, ready=1 on the next cycle, no done; a following add of 0x0F0F+0xF0F1 -> sum=0x0000, cy_out=1.
REQ-032 The bench SHALL use WIDTH=8, DIGIT=8 with a=0x80, b=0x80 -> sum=0x00, cy_out=1, ovf=1, done 2 cycles after start.
